carregador_programa: RTL

Program loader and instruction store for the 8-bit nRisc core, sitting directly upstream of the core's instruction input. After reset it accepts a byte-stream program image over a valid/ready handshake: first a length byte, then that many instruction bytes. While loading it holds the core in reset. Once the image is complete it releases the core and serves `Instrucao` combinationally from the core's PC address (`SaidaPCLeEndereco`).

---
 rtl/carregador_programa_if.sv | 12 +
 rtl/carregador_programa.sv | 117 +++++++++++
 2 files changed

// File: rtl/carregador_programa_if.sv
// Byte-stream loader handshake for carregador_programa. A byte moves on a
// rising edge where carga_valida and carga_pronta are both high.
interface carregador_programa_if #(
    parameter int DATA_W = 8
);
    logic              carga_valida;
    logic [DATA_W-1:0] carga_dado;
    logic              carga_pronta;

    modport master (output carga_valida, output carga_dado, input  carga_pronta);
    modport slave  (input  carga_valida, input  carga_dado, output carga_pronta);
endinterface

// File: rtl/carregador_programa.sv
// Program loader and instruction store for the nRisc core: takes a length byte
// plus image bytes, holds the core in reset meanwhile, then serves fetches.
module carregador_programa #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  Clock,
    input  logic                  reset,
    carregador_programa_if.slave  carga,
    input  logic                  recarga,
    input  logic [ADDR_W-1:0]     SaidaPCLeEndereco,
    output logic [DATA_W-1:0]     Instrucao,
    output logic                  reset_nucleo,
    output logic [ADDR_W:0]       tamanho,
    output logic                  fora_faixa
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ESPERA_TAM = 2'd0,
        CARREGA    = 2'd1,
        EXECUTA    = 2'd2
    } estado_t;

    estado_t           r_estado;
    estado_t           w_estado_prox;
    logic [ADDR_W:0]   r_tamanho;
    logic [ADDR_W:0]   r_cont;
    logic              r_fora_faixa;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_pronta;
    logic              w_xfer;
    logic              w_ultimo;
    logic              w_em_faixa;
    logic              w_reset_nucleo;
    logic [ADDR_W:0]   w_len_bruto;
    logic [ADDR_W:0]   w_len;

    // Loader is never ready during reset, so no byte can sneak in on a reset edge.
    assign w_pronta   = !reset && (r_estado != EXECUTA);
    assign w_xfer     = carga.carga_valida && w_pronta;
    assign w_ultimo   = ((r_cont + 1'b1) == r_tamanho);
    assign w_em_faixa = ({1'b0, SaidaPCLeEndereco} < r_tamanho);

    // A length byte of zero stands for a full 2^ADDR_W image.
    assign w_len_bruto = {1'b0, carga.carga_dado[ADDR_W-1:0]};
    assign w_len       = (w_len_bruto == '0) ? {1'b1, {ADDR_W{1'b0}}} : w_len_bruto;

    always_ff @(posedge Clock) begin
        if (reset) r_estado <= ESPERA_TAM;
        else       r_estado <= w_estado_prox;
    end

    always_comb begin
        w_estado_prox  = r_estado;
        w_reset_nucleo = 1'b1;
        case (r_estado)
            ESPERA_TAM: begin
                if (w_xfer) w_estado_prox = CARREGA;
            end
            CARREGA: begin
                if (w_xfer && w_ultimo) w_estado_prox = EXECUTA;
            end
            EXECUTA: begin
                w_reset_nucleo = 1'b0;
                if (recarga) w_estado_prox = ESPERA_TAM;
            end
            default: w_estado_prox = ESPERA_TAM;
        endcase
        if (reset) w_reset_nucleo = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            r_tamanho    <= '0;
            r_cont       <= '0;
            r_fora_faixa <= 1'b0;
        end else begin
            case (r_estado)
                ESPERA_TAM: begin
                    if (w_xfer) begin
                        r_tamanho <= w_len;
                        r_cont    <= '0;
                    end
                end
                CARREGA: begin
                    if (w_xfer) r_cont <= r_cont + 1'b1;
                end
                EXECUTA: begin
                    // recarga takes priority over an out-of-range fetch in the same cycle
                    if (recarga)          r_fora_faixa <= 1'b0;
                    else if (!w_em_faixa) r_fora_faixa <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Store is deliberately not reset; the range check hides stale bytes.
    always_ff @(posedge Clock) begin
        if (r_estado == CARREGA && w_xfer)
            r_mem[r_cont[ADDR_W-1:0]] <= carga.carga_dado;
    end

    assign carga.carga_pronta = w_pronta;
    assign reset_nucleo       = w_reset_nucleo;
    assign tamanho            = r_tamanho;
    assign fora_faixa         = r_fora_faixa;
    assign Instrucao          = (r_estado == EXECUTA && w_em_faixa) ?
                                r_mem[SaidaPCLeEndereco] : '0;

    a_cont_abaixo_tam: assert property (@(posedge Clock) disable iff (reset)
        (r_estado == CARREGA) |-> (r_cont < r_tamanho));
    a_sem_pronta_exec: assert property (@(posedge Clock) disable iff (reset)
        (r_estado == EXECUTA) |-> !carga.carga_pronta);
endmodule
